// File: rtl/disp_src_arbiter.sv
// rtl/disp_src_arbiter.sv - time-shares the seven-segment display among one alert and two round-robin sources
//
// Ports:
//   fpga_clk        system clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   req[2:0]        level request per source, bit 0 is the alert source
//   data0..data2    per-source display word {state, hex_3, hex_2, hex_1, hex_0}
//   grant[2:0]      one-hot current owner, zero when idle
//   busy            any grant active
//   ack[2:0]        one-cycle pulse in the cycle after source i loses the grant
//   sm_state        state digit to the display driver
//   hex_0..hex_3    hex digits to the display driver

module disp_src_arbiter #(
    parameter int CLK_DIV  = 100000,
    parameter int DWELL_MS = 1000
) (
    input  logic        fpga_clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [19:0] data0,
    input  logic [19:0] data1,
    input  logic [19:0] data2,
    output logic [2:0]  grant,
    output logic        busy,
    output logic [2:0]  ack,
    output logic [3:0]  sm_state,
    output logic [3:0]  hex_0,
    output logic [3:0]  hex_1,
    output logic [3:0]  hex_2,
    output logic [3:0]  hex_3
);

    localparam int          CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [15:0] DWELL_MAX  = 16'(DWELL_MS);
    localparam logic [15:0] DWELL_PRE  = 16'(DWELL_MS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          tick;
    logic [15:0]   dwell_q, dwell_d, dwell_inc;
    // rr_q: 0 means source 1 wins next, 1 means source 2 wins next
    logic          rr_q, rr_d;
    logic [2:0]    grant_q, grant_d;
    logic [2:0]    ack_q, ack_d;
    logic          busy_q;
    logic [19:0]   disp_q, disp_d;
    logic [2:0]    others;
    logic [2:0]    win;
    logic [19:0]   win_data;
    logic [19:0]   owner_data;
    logic          expired;
    logic          owner_req;

    // Alert first, then the source named by the round-robin pointer, then the other one.
    function automatic logic [2:0] pick(input logic [2:0] r, input logic rr_sel);
        logic [2:0] w;
        w = 3'b000;
        if (r[0]) begin
            w = 3'b001;
        end else if (!rr_sel) begin
            if (r[1])      w = 3'b010;
            else if (r[2]) w = 3'b100;
        end else begin
            if (r[2])      w = 3'b100;
            else if (r[1]) w = 3'b010;
        end
        return w;
    endfunction

    function automatic logic [19:0] sel_data(input logic [2:0] g, input logic [19:0] d0,
                                             input logic [19:0] d1, input logic [19:0] d2);
        logic [19:0] d;
        d = 20'h00000;
        if (g[0])      d = d0;
        else if (g[1]) d = d1;
        else if (g[2]) d = d2;
        return d;
    endfunction

    // Free-running ms tick; its phase is never realigned to a grant.
    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_comb begin
        others     = req & ~grant_q;
        owner_req  = |(req & grant_q);
        win        = pick((state_q == IDLE) ? req : others, rr_q);
        win_data   = sel_data(win, data0, data1, data2);
        owner_data = sel_data(grant_q, data0, data1, data2);
        dwell_inc  = (tick && (dwell_q != DWELL_MAX)) ? dwell_q + 16'd1 : dwell_q;
        // Expires either once saturated or on the tick that would saturate it,
        // so the handover lands exactly on the dwell boundary.
        expired    = (dwell_q == DWELL_MAX) || (tick && (dwell_q == DWELL_PRE));
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        dwell_d = dwell_q;
        rr_d    = rr_q;
        ack_d   = 3'b000;
        disp_d  = disp_q;

        case (state_q)
            IDLE: begin
                grant_d = 3'b000;
                disp_d  = 20'h00000;
                if (|req) begin
                    grant_d = win;
                    dwell_d = 16'd0;
                    disp_d  = win_data;
                    state_d = SHOW;
                end
            end

            SHOW: begin
                if (req[0] && !grant_q[0]) begin
                    // Preemption by the alert source; rr deliberately untouched
                    // so the preempted source is not counted as served.
                    grant_d = 3'b001;
                    ack_d   = grant_q;
                    dwell_d = 16'd0;
                    disp_d  = data0;
                end else if (expired && ((|others) || !owner_req)) begin
                    ack_d   = grant_q;
                    dwell_d = 16'd0;
                    if (grant_q[1])      rr_d = 1'b1;
                    else if (grant_q[2]) rr_d = 1'b0;
                    if (|others) begin
                        grant_d = win;
                        disp_d  = win_data;
                    end else begin
                        grant_d = 3'b000;
                        disp_d  = 20'h00000;
                        state_d = IDLE;
                    end
                end else begin
                    // Includes the saturated case where the owner alone keeps requesting.
                    dwell_d = dwell_inc;
                    if (owner_req) begin
                        disp_d = owner_data;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
                dwell_d = 16'd0;
                disp_d  = 20'h00000;
            end
        endcase
    end

    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            ack_q   <= 3'b000;
            busy_q  <= 1'b0;
            dwell_q <= 16'd0;
            rr_q    <= 1'b0;
            disp_q  <= 20'h00000;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            busy_q  <= |grant_d;
            dwell_q <= dwell_d;
            rr_q    <= rr_d;
            disp_q  <= disp_d;
        end
    end

    assign grant    = grant_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign sm_state = disp_q[19:16];
    assign hex_3    = disp_q[15:12];
    assign hex_2    = disp_q[11:8];
    assign hex_1    = disp_q[7:4];
    assign hex_0    = disp_q[3:0];

endmodule

// File: tb/tb_disp_src_arbiter.sv
// tb/tb_disp_src_arbiter.sv - self-checking bench for disp_src_arbiter against a source-level reference model

module tb_disp_src_arbiter;

    localparam int CD = 4;
    localparam int DW = 3;

    logic        fpga_clk = 1'b0;
    logic        rst      = 1'b1;
    logic [2:0]  req      = 3'b000;
    logic [19:0] data0    = 20'h0;
    logic [19:0] data1    = 20'h0;
    logic [19:0] data2    = 20'h0;
    logic [2:0]  grant;
    logic        busy;
    logic [2:0]  ack;
    logic [3:0]  sm_state, hex_0, hex_1, hex_2, hex_3;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: owner index (-1 idle), elapsed ms, next low-priority winner (1 or 2)
    int          m_owner = -1;
    int          m_dwell = 0;
    int          m_rr    = 1;
    int          m_cnt   = 0;
    logic [2:0]  m_ack   = 3'b000;
    logic [19:0] m_disp  = 20'h0;

    disp_src_arbiter #(.CLK_DIV(CD), .DWELL_MS(DW)) dut (
        .fpga_clk (fpga_clk),
        .rst      (rst),
        .req      (req),
        .data0    (data0),
        .data1    (data1),
        .data2    (data2),
        .grant    (grant),
        .busy     (busy),
        .ack      (ack),
        .sm_state (sm_state),
        .hex_0    (hex_0),
        .hex_1    (hex_1),
        .hex_2    (hex_2),
        .hex_3    (hex_3)
    );

    always #5 fpga_clk = ~fpga_clk;

    function automatic logic [2:0] onehot(input int i);
        return (i < 0) ? 3'b000 : 3'(1 << i);
    endfunction

    function automatic logic [19:0] dat(input int i);
        return (i == 0) ? data0 : (i == 1) ? data1 : data2;
    endfunction

    function automatic int mpick(input logic [2:0] r, input int rrv);
        if (r[0])       return 0;
        if (r[rrv])     return rrv;
        if (r[3 - rrv]) return 3 - rrv;
        return -1;
    endfunction

    task automatic model_update();
        bit         tk;
        bit         expd;
        logic [2:0] oth;
        int         w;
        tk = (m_cnt == CD - 1);
        if (rst) begin
            m_owner = -1; m_dwell = 0; m_rr = 1; m_cnt = 0; m_ack = 3'b000; m_disp = 20'h0;
            return;
        end
        m_cnt = tk ? 0 : m_cnt + 1;
        m_ack = 3'b000;
        if (m_owner < 0) begin
            w = mpick(req, m_rr);
            if (w >= 0) begin
                m_owner = w; m_dwell = 0; m_disp = dat(w);
            end
        end else if (req[0] && m_owner != 0) begin
            m_ack = onehot(m_owner); m_owner = 0; m_dwell = 0; m_disp = data0;
        end else begin
            expd = (m_dwell >= DW) || (tk && m_dwell == DW - 1);
            oth  = req & ~onehot(m_owner);
            if (expd && (oth != 3'b000 || !req[m_owner])) begin
                m_ack = onehot(m_owner);
                w = mpick(oth, m_rr);
                if (m_owner != 0) m_rr = 3 - m_owner;
                m_dwell = 0;
                if (w >= 0) begin
                    m_owner = w; m_disp = dat(w);
                end else begin
                    m_owner = -1; m_disp = 20'h0;
                end
            end else begin
                if (tk && m_dwell < DW) m_dwell++;
                if (req[m_owner]) m_disp = dat(m_owner);
            end
        end
    endtask

    task automatic step(input logic r, input logic [2:0] q, input bit rnd);
        logic [19:0] disp;
        rst = r;
        req = q;
        if (rnd) begin
            data0 = 20'($urandom);
            data1 = 20'($urandom);
            data2 = 20'($urandom);
        end
        @(posedge fpga_clk);
        model_update();
        #1;
        n_vec++;
        disp = {sm_state, hex_3, hex_2, hex_1, hex_0};
        assert (grant === onehot(m_owner)) else begin
            n_err++; $error("FAIL grant: got %b want %b", grant, onehot(m_owner));
        end
        assert (busy === (m_owner >= 0)) else begin
            n_err++; $error("FAIL busy: got %b want %b", busy, (m_owner >= 0));
        end
        assert (ack === m_ack) else begin
            n_err++; $error("FAIL ack: got %b want %b", ack, m_ack);
        end
        assert (disp === m_disp) else begin
            n_err++; $error("FAIL display: got %h want %h", disp, m_disp);
        end
    endtask

    initial begin
        int glen;
        bit acked;
        logic [2:0] rq;

        // Reset held with all requests active
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 3'b111, 1'b1);
            assert (grant === 3'b000 && busy === 1'b0 && {sm_state, hex_3, hex_2, hex_1, hex_0} === 20'h0) else begin
                n_err++; $error("FAIL reset_outputs: got %b/%b want 000/0", grant, busy);
            end
        end
        step(1'b0, 3'b111, 1'b1);
        assert (grant === 3'b001) else begin
            n_err++; $error("FAIL post_reset_grant: got %b want 001", grant);
        end
        for (int i = 0; i < 16; i++) step(1'b0, 3'b000, 1'b1);

        // Single pulse from source 1, display frozen on its word
        data1 = 20'h5ABCD;
        step(1'b0, 3'b010, 1'b0);
        glen  = 0;
        acked = 1'b0;
        if (grant === 3'b010) glen++;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 3'b000, 1'b1);
            if (grant === 3'b010) begin
                glen++;
                assert ({sm_state, hex_3, hex_2, hex_1, hex_0} === 20'h5ABCD) else begin
                    n_err++; $error("FAIL frozen_digits: got %h want 5abcd", {sm_state, hex_3, hex_2, hex_1, hex_0});
                end
            end
            if (ack === 3'b010) acked = 1'b1;
        end
        assert (glen >= 9 && glen <= 12 && acked) else begin
            n_err++; $error("FAIL dwell_len: got %0d cycles ack %b want 9..12 ack 1", glen, acked);
        end

        // Round-robin between sources 1 and 2
        for (int i = 0; i < 40; i++) step(1'b0, 3'b110, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 3'b000, 1'b1);

        // Preemption of source 2 by the alert source
        for (int i = 0; i < 5; i++) step(1'b0, 3'b100, 1'b1);
        step(1'b0, 3'b101, 1'b1);
        assert (grant === 3'b001 && ack === 3'b100) else begin
            n_err++; $error("FAIL preempt: got grant %b ack %b want 001/100", grant, ack);
        end
        for (int i = 0; i < 30; i++) step(1'b0, 3'b100, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 3'b000, 1'b1);

        // Saturated dwell with a lone requester, then a competitor arrives
        for (int i = 0; i < 80; i++) begin
            step(1'b0, 3'b010, 1'b1);
            if (i > 0) begin
                assert (grant === 3'b010) else begin
                    n_err++; $error("FAIL saturate_hold: got %b want 010", grant);
                end
            end
        end
        step(1'b0, 3'b110, 1'b1);
        assert (grant === 3'b100 && ack === 3'b010) else begin
            n_err++; $error("FAIL saturate_handover: got grant %b ack %b want 100/010", grant, ack);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 3'b110, 1'b1);

        // Random traffic with occasional reset
        rq = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                rq[0] = ($urandom_range(7, 0) == 0);
                rq[1] = 1'($urandom);
                rq[2] = 1'($urandom);
            end
            step(($urandom_range(199, 0) == 0), rq, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
